// File: rtl/led_owner_sched.sv
// rtl/led_owner_sched.sv - priority scheduler sharing the active-low red/green status LED pair
// between three requesters, with tick prescaler, blink phase and anti-flicker hold.
module led_owner_sched #(
  parameter int TICK_DIV   = 177333,
  parameter int HOLD_TICKS = 30,
  parameter int CW         = 32
) (
  input  logic        Clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic [11:0] pat,
  output logic [2:0]  grant,
  output logic        red,
  output logic        green,
  output logic        tick
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] PRESC_RELOAD = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRESC_ONE    = CW'(1);
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_ONE     = HW'(1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic [CW-1:0] presc;
  logic [4:0]    phase;
  logic [HW-1:0] hold;

  logic [2:0] grant_nxt;
  logic [2:0] higher;
  logic [3:0] field;
  logic       red_nxt;
  logic       green_nxt;

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[0])      return 3'b001;
    else if (r[1]) return 3'b010;
    else if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  // Arbitration: a dropped owner re-arbitrates at once; preemption waits for the hold to expire.
  always_comb begin
    grant_nxt = grant;
    higher    = req & (grant - 3'd1);
    case (state)
      IDLE: grant_nxt = pick(req);
      OWN: begin
        if ((req & grant) == 3'b000)
          grant_nxt = pick(req);
        else if (higher != 3'b000 && hold == '0)
          grant_nxt = pick(req);
      end
      default: grant_nxt = 3'b000;
    endcase
  end

  always_comb begin
    field     = 4'b0000;
    red_nxt   = 1'b1;
    green_nxt = 1'b1;
    case (grant)
      3'b001:  field = pat[3:0];
      3'b010:  field = pat[7:4];
      3'b100:  field = pat[11:8];
      default: field = 4'b0000;
    endcase
    case (field[1:0])
      2'b01: begin
        red_nxt   = ~field[2];
        green_nxt = ~field[3];
      end
      2'b10: begin
        if (!phase[4]) begin
          red_nxt   = ~field[2];
          green_nxt = ~field[3];
        end
      end
      2'b11: begin
        red_nxt   = phase[4];
        green_nxt = ~phase[4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      presc <= PRESC_RELOAD;
      tick  <= 1'b0;
      state <= IDLE;
      grant <= 3'b000;
      phase <= 5'd0;
      hold  <= '0;
      red   <= 1'b1;
      green <= 1'b1;
    end else begin
      if (presc == '0) presc <= PRESC_RELOAD;
      else             presc <= presc - PRESC_ONE;
      // Registered so that tick is high exactly while the counter sits at zero.
      tick <= (presc == PRESC_ONE);

      grant <= grant_nxt;
      state <= (grant_nxt != 3'b000) ? OWN : IDLE;

      if (grant_nxt != grant) begin
        phase <= 5'd0;
        hold  <= HOLD_LOAD;
      end else if (tick) begin
        phase <= phase + 5'd1;
        if (hold != '0) hold <= hold - HOLD_ONE;
      end

      red   <= red_nxt;
      green <= green_nxt;
    end
  end

endmodule

// File: tb/tb_led_owner_sched.sv
// tb/tb_led_owner_sched.sv - scoreboard bench for led_owner_sched with TICK_DIV=4, HOLD_TICKS=2.
module tb_led_owner_sched;

  localparam int B    = 4;
  localparam int K_GR = 0;
  localparam int K_RD = 1;
  localparam int K_GN = 2;
  localparam int K_TK = 3;

  logic        Clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [11:0] pat;
  logic [2:0]  grant;
  logic        red;
  logic        green;
  logic        tick;

  typedef struct {
    int         cyc;
    int         kind;
    logic [2:0] val;
    string      nm;
  } chk_t;

  chk_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  led_owner_sched #(.TICK_DIV(4), .HOLD_TICKS(2), .CW(32)) dut (
    .Clk(Clk), .sys_rst(sys_rst), .req(req), .pat(pat),
    .grant(grant), .red(red), .green(green), .tick(tick)
  );

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: each cycle, pop every expectation due now and compare with the live outputs.
  always @(negedge Clk) begin : mon
    chk_t       it;
    logic [2:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      case (it.kind)
        K_GR:    act = grant;
        K_RD:    act = {2'b00, red};
        K_GN:    act = {2'b00, green};
        default: act = {2'b00, tick};
      endcase
      n_chk++;
      if (act !== it.val || it.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: got %b, expected %b", it.nm, it.cyc - B, act, it.val);
      end
    end
  end

  task automatic ex(input int c, input int kind, input int val, input string nm);
    chk_t it;
    int   i;
    it.cyc  = B + c;
    it.kind = kind;
    it.val  = 3'(val);
    it.nm   = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > it.cyc) i--;
    sb.insert(i, it);
  endtask

  task automatic wait_c(input int c);
    while (cyc < B + c) @(negedge Clk);
  endtask

  initial begin
    sys_rst = 1'b1;
    req     = 3'b000;
    pat     = 12'h000;
    for (int c = -2; c <= -1; c++) begin
      ex(c, K_GR, 0, "rst_grant");
      ex(c, K_RD, 1, "rst_red");
      ex(c, K_GN, 1, "rst_green");
      ex(c, K_TK, 0, "rst_tick");
    end

    // 1: idle after reset, ticks every 4 cycles starting at cycle 3
    wait_c(0);
    sys_rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      ex(c, K_TK, (c % 4 == 3) ? 1 : 0, "t1_tick");
      ex(c, K_GR, 0, "t1_grant");
      ex(c, K_RD, 1, "t1_red");
      ex(c, K_GN, 1, "t1_green");
    end

    // 2: requester 2, green blink; 16 ticks on, 16 off
    wait_c(12);
    req = 3'b100;
    pat = {4'b1010, 4'b0011, 4'b0110};
    ex(13, K_GR, 3'b100, "t2_grant");
    ex(14, K_RD, 1, "t2_red");
    ex(14, K_GN, 0, "t2_green_on");
    ex(76, K_GN, 0, "t2_green_last_on");
    ex(77, K_GN, 1, "t2_green_off");
    ex(100, K_RD, 1, "t2_red_mid");
    ex(140, K_GN, 1, "t2_green_last_off");
    ex(141, K_GN, 0, "t2_green_on_again");

    wait_c(144);
    req = 3'b000;
    ex(145, K_GR, 0, "t2_idle_grant");
    ex(145, K_GN, 0, "t2_idle_green_lag");
    ex(146, K_GN, 1, "t2_idle_green");
    ex(146, K_RD, 1, "t2_idle_red");

    // 3: higher priority waits for the hold to expire
    wait_c(148);
    req = 3'b100;
    ex(149, K_GR, 3'b100, "t3_grant");
    ex(150, K_GN, 0, "t3_green");
    wait_c(149);
    req = 3'b101;
    ex(150, K_GR, 3'b100, "t3_hold1");
    ex(156, K_GR, 3'b100, "t3_hold2");
    ex(157, K_GR, 3'b001, "t3_preempt");
    ex(158, K_RD, 0, "t3_red_on");
    ex(158, K_GN, 1, "t3_green_off");
    ex(220, K_RD, 0, "t3_phase_last_on");
    ex(221, K_RD, 1, "t3_phase_off");
    ex(221, K_GN, 1, "t3_green_still_off");

    // 4: owner drop re-arbitrates immediately even with hold loaded
    wait_c(224);
    req = 3'b000;
    ex(225, K_GR, 0, "t4_idle");
    wait_c(228);
    req = 3'b001;
    ex(229, K_GR, 3'b001, "t4_grant0");
    wait_c(229);
    req = 3'b110;
    ex(230, K_GR, 3'b010, "t4_drop_regrant");

    // 5: requester 1 alternate mode, then a reset pulse
    for (int c = 231; c <= 360; c++) begin
      ex(c, K_RD, (c >= 293 && c <= 356) ? 1 : 0, "t5_alt_red");
      ex(c, K_GN, (c >= 293 && c <= 356) ? 0 : 1, "t5_alt_green");
    end
    wait_c(360);
    sys_rst = 1'b1;
    req     = 3'b000;
    ex(361, K_GR, 0, "t5_rst_grant");
    ex(361, K_RD, 1, "t5_rst_red");
    ex(361, K_GN, 1, "t5_rst_green");
    ex(361, K_TK, 0, "t5_rst_tick");
    wait_c(361);
    sys_rst = 1'b0;
    ex(362, K_GR, 0, "t5_post_grant");
    ex(362, K_TK, 0, "t5_post_tick");
    ex(363, K_TK, 0, "t5_post_tick");
    ex(364, K_TK, 1, "t5_first_tick");
    ex(365, K_TK, 0, "t5_post_tick");
    ex(368, K_TK, 1, "t5_second_tick");

    // 6: owner drop on the tick edge
    wait_c(368);
    req = 3'b100;
    ex(369, K_GR, 3'b100, "t6_grant");
    ex(370, K_GN, 0, "t6_green");
    ex(370, K_RD, 1, "t6_red");
    wait_c(375);
    req = 3'b000;
    ex(376, K_GR, 0, "t6_idle");
    ex(376, K_TK, 1, "t6_tick_same");
    ex(376, K_GN, 0, "t6_green_lag");
    ex(377, K_GN, 1, "t6_green_off");
    ex(377, K_RD, 1, "t6_red_off");
    ex(377, K_GR, 0, "t6_idle_hold");
    for (int c = 377; c <= 379; c++) ex(c, K_TK, 0, "t6_tick_gap");
    ex(380, K_TK, 1, "t6_tick_next");

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
